// File: rtl/wb_burst_master_ctrl.sv
// wb_burst_master_ctrl
// WISHBONE pipelined burst master. It sends one queued message as a single bus
// cycle. It limits the number of outstanding beats, drives incrementing-burst
// CTI, retries on RTY_I with a backoff delay, and fails the message on ERR_I.
// Optional feature: define WB_MST_TIMEOUT_EN to enable the ACK watchdog.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | bus released; waiting for the queue to hold a message
// S_REQ     | CYC_O high; waiting for the arbiter grant
// S_ISSUE   | strobing beats, subject to the outstanding-beat limit
// S_WAIT    | all beats issued; collecting the remaining ACKs
// S_BACKOFF | after an RTY abort, bus released for BACKOFF_CYC cycles
module wb_burst_master_ctrl #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TGA_W       = 8,
   parameter int TGC_W       = 8,
   parameter int BURST_W     = 7,
   parameter int MAX_OUT     = 4,
   parameter int MAX_RETRY   = 3,
   parameter int BACKOFF_CYC = 8,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_i,
   input  logic                we_i,
   input  logic [ADDR_W-1:0]   adr_i,
   input  logic [DATA_W-1:0]   dat_i,
   input  logic [DATA_W/8-1:0] sel_i,
   input  logic [TGA_W-1:0]    tga_i,
   input  logic [TGC_W-1:0]    tgc_i,
   input  logic [BURST_W-1:0]  burst_len_i,
   output logic                next_data_o,
   output logic                done_o,
   output logic                retry_o,
   output logic                err_o,
   output logic                busy_o,
   output logic                CYC_O,
   output logic                STB_O,
   output logic                WE_O,
   output logic [ADDR_W-1:0]   ADR_O,
   output logic [DATA_W-1:0]   DAT_O,
   output logic [DATA_W/8-1:0] SEL_O,
   output logic [TGA_W-1:0]    TGA_O,
   output logic [TGC_W-1:0]    TGC_O,
   output logic [2:0]          CTI_O,
   input  logic                ACK_I,
   input  logic                RTY_I,
   input  logic                ERR_I,
   input  logic                STALL_I,
   input  logic                gnt_wb_i
);

   localparam int BO_W = (BACKOFF_CYC > 1) ? $clog2(BACKOFF_CYC) : 1;
   localparam int RT_W = $clog2(MAX_RETRY + 2);

   localparam logic [BURST_W-1:0] ONE_B   = BURST_W'(1);
   localparam logic [BURST_W-1:0] MAX_OUT_B = BURST_W'(MAX_OUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_ISSUE,
      S_WAIT,
      S_BACKOFF
   } state_t;

   state_t             state, state_n;
   logic [BURST_W-1:0] len, len_n;
   logic               we_lat, we_n;
   logic [BURST_W-1:0] sent, sent_n;
   logic [BURST_W-1:0] acked, acked_n;
   logic [RT_W-1:0]    retry_cnt, retry_n;
   logic [BO_W-1:0]    bo_cnt, bo_n;

   logic [BURST_W-1:0] outstanding;
   logic               cyc, stb, accept, ack_ok, last_beat;
   logic [2:0]         cti;
   logic               nd_c, done_c, retry_c, err_c;
   logic               wd_fire;

   assign outstanding = sent - acked;
   assign last_beat   = (sent == (len - ONE_B));

`ifdef WB_MST_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   logic [WD_W-1:0] wd_cnt;
   logic            wd_silent;

   assign wd_silent = ((state == S_ISSUE) || (state == S_WAIT)) &&
                      (outstanding != '0) && !ACK_I && !RTY_I && !ERR_I;
   assign wd_fire   = wd_silent && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

   // Watchdog: counts silent cycles with beats outstanding, cleared otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt <= '0;
      end else if (wd_silent && !wd_fire) begin
         wd_cnt <= wd_cnt + WD_W'(1);
      end else begin
         wd_cnt <= '0;
      end
   end
`else
   // Watchdog absent: the expression is constant false and the master waits indefinitely
   assign wd_fire = (TIMEOUT_CYC < 0);
`endif

   // State and message bookkeeping registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         len       <= '0;
         we_lat    <= 1'b0;
         sent      <= '0;
         acked     <= '0;
         retry_cnt <= '0;
         bo_cnt    <= '0;
      end else begin
         state     <= state_n;
         len       <= len_n;
         we_lat    <= we_n;
         sent      <= sent_n;
         acked     <= acked_n;
         retry_cnt <= retry_n;
         bo_cnt    <= bo_n;
      end
   end

   // Next-state, counter updates and bus outputs
   always_comb begin
      state_n = state;
      len_n   = len;
      we_n    = we_lat;
      sent_n  = sent;
      acked_n = acked;
      retry_n = retry_cnt;
      bo_n    = bo_cnt;
      cyc     = 1'b0;
      stb     = 1'b0;
      cti     = 3'b000;
      accept  = 1'b0;
      ack_ok  = 1'b0;
      nd_c    = 1'b0;
      done_c  = 1'b0;
      retry_c = 1'b0;
      err_c   = 1'b0;

      case (state)
         S_IDLE: begin
            if (req_i) begin
               state_n = S_REQ;
               len_n   = (burst_len_i == '0) ? ONE_B : burst_len_i;
               we_n    = we_i;
               sent_n  = '0;
               acked_n = '0;
               retry_n = '0;
            end
         end

         S_REQ: begin
            cyc = 1'b1;
            if (gnt_wb_i) begin
               state_n = S_ISSUE;
            end
         end

         S_ISSUE, S_WAIT: begin
            cyc = 1'b1;
            if (state == S_ISSUE) begin
               stb = (sent < len) && (outstanding < MAX_OUT_B);
            end
            if (stb) begin
               if (len == ONE_B) begin
                  cti = 3'b000;
               end else if (last_beat) begin
                  cti = 3'b111;
               end else begin
                  cti = 3'b010;
               end
            end
            accept = stb && !STALL_I;
            // An ACK with nothing outstanding cannot belong to this cycle
            ack_ok = ACK_I && (outstanding != '0);

            if (ERR_I || wd_fire) begin
               err_c   = 1'b1;
               state_n = S_IDLE;
               sent_n  = '0;
               acked_n = '0;
               retry_n = '0;
            end else if (RTY_I) begin
               sent_n  = '0;
               acked_n = '0;
               if (retry_cnt < RT_W'(MAX_RETRY)) begin
                  retry_c = 1'b1;
                  retry_n = retry_cnt + RT_W'(1);
                  bo_n    = BO_W'(BACKOFF_CYC - 1);
                  state_n = S_BACKOFF;
               end else begin
                  err_c   = 1'b1;
                  retry_n = '0;
                  state_n = S_IDLE;
               end
            end else begin
               if (accept) begin
                  sent_n = sent + ONE_B;
                  // The queue already presents the last beat; no advance past it
                  nd_c   = !last_beat;
               end
               if (ack_ok) begin
                  acked_n = acked + ONE_B;
               end
               if (ack_ok && (acked == (len - ONE_B))) begin
                  done_c  = 1'b1;
                  state_n = S_IDLE;
                  sent_n  = '0;
                  acked_n = '0;
                  retry_n = '0;
               end else if ((state == S_ISSUE) && (sent_n == len)) begin
                  state_n = S_WAIT;
               end
            end
         end

         S_BACKOFF: begin
            if (bo_cnt == '0) begin
               state_n = S_REQ;
            end else begin
               bo_n = bo_cnt - BO_W'(1);
            end
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // Pulses are suppressed while reset is asserted so an abort never reports an outcome
   assign next_data_o = nd_c && !rst;
   assign done_o      = done_c && !rst;
   assign retry_o     = retry_c && !rst;
   assign err_o       = err_c && !rst;
   assign busy_o      = (state != S_IDLE);

   assign CYC_O = cyc;
   assign STB_O = stb;
   assign CTI_O = cti;
   assign WE_O  = cyc && we_lat;
   assign ADR_O = cyc ? adr_i : '0;
   assign DAT_O = cyc ? dat_i : '0;
   assign SEL_O = cyc ? sel_i : '0;
   assign TGA_O = cyc ? tga_i : '0;
   assign TGC_O = cyc ? tgc_i : '0;

endmodule

// File: tb/tb_wb_burst_master_ctrl.sv
// Testbench for wb_burst_master_ctrl: table of burst messages against a slave
// model, plus hand-written retry, error, watchdog and reset sequences.
module tb_wb_burst_master_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_i, we_i;
   logic [31:0] adr_i, dat_i;
   logic [3:0]  sel_i;
   logic [7:0]  tga_i, tgc_i;
   logic [6:0]  burst_len_i;
   logic        next_data_o, done_o, retry_o, err_o, busy_o;
   logic        CYC_O, STB_O, WE_O;
   logic [31:0] ADR_O, DAT_O;
   logic [3:0]  SEL_O;
   logic [7:0]  TGA_O, TGC_O;
   logic [2:0]  CTI_O;
   logic        ACK_I, RTY_I, ERR_I, STALL_I, gnt_wb_i;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wb_burst_master_ctrl #(
      .MAX_OUT(4), .MAX_RETRY(3), .BACKOFF_CYC(8), .TIMEOUT_CYC(16)
   ) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .adr_i(adr_i),
      .dat_i(dat_i), .sel_i(sel_i), .tga_i(tga_i), .tgc_i(tgc_i),
      .burst_len_i(burst_len_i), .next_data_o(next_data_o), .done_o(done_o),
      .retry_o(retry_o), .err_o(err_o), .busy_o(busy_o), .CYC_O(CYC_O),
      .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O),
      .TGA_O(TGA_O), .TGC_O(TGC_O), .CTI_O(CTI_O), .ACK_I(ACK_I),
      .RTY_I(RTY_I), .ERR_I(ERR_I), .STALL_I(STALL_I), .gnt_wb_i(gnt_wb_i)
   );

   typedef struct {
      logic [6:0]  len;
      logic        we;
      int          lat;
      logic [15:0] stall;
      int          beats;
      int          nd;
      int          maxo;
      int          cyc;
   } vec_t;

   vec_t vt [7];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Pulse req_i for one IDLE cycle; returns at the negedge of the first REQ cycle
   task automatic start_msg(input logic [6:0] len, input logic we);
      @(negedge clk);
      req_i = 1'b1; we_i = we; burst_len_i = len; gnt_wb_i = 1'b1;
      @(negedge clk);
      req_i = 1'b0;
   endtask

   // Count cycles with CYC_O low (bounded); called at a sample point
   task automatic count_backoff(output int n);
      n = 0;
      while (!CYC_O && n < 50) begin
         n++;
         @(negedge clk); #1;
      end
   endtask

   initial begin
      int k, len_eff, sent_b, acks_b, nd_cnt, done_cnt, cyc_cnt, maxo, n;
      logic [15:0] ack_sr;
      logic exp_stb, exp_acc, exp_done;
      logic [2:0] exp_cti;

      vt[0] = '{7'd1, 1'b1, 1, 16'h0000, 1, 0, 1, 3};
      vt[1] = '{7'd8, 1'b0, 5, 16'h0000, 8, 7, 4, 16};
      vt[2] = '{7'd8, 1'b0, 3, 16'h0000, 8, 7, 3, 12};
      vt[3] = '{7'd4, 1'b1, 1, 16'h000E, 4, 3, 1, 9};
      vt[4] = '{7'd0, 1'b0, 2, 16'h0000, 1, 0, 1, 4};
      vt[5] = '{7'd2, 1'b1, 1, 16'h0000, 2, 1, 1, 4};
      vt[6] = '{7'd3, 1'b1, 2, 16'h0004, 3, 2, 2, 7};

      rst = 1'b1; req_i = 1'b0; we_i = 1'b1; adr_i = 32'hDEAD_BEEF;
      dat_i = 32'h1234_5678; sel_i = 4'hF; tga_i = 8'h5A; tgc_i = 8'hA5;
      burst_len_i = 7'd3; ACK_I = 1'b0; RTY_I = 1'b0; ERR_I = 1'b0;
      STALL_I = 1'b0; gnt_wb_i = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset cyc", CYC_O, 0);
      chk("reset stb", STB_O, 0);
      chk("reset busy", busy_o, 0);
      chk("reset pulses", {done_o, retry_o, err_o, next_data_o}, 0);
      chk("reset we", WE_O, 0);
      chk("reset cti", CTI_O, 0);
      chk("reset adr", ADR_O, 0);

      // Table-driven messages against a fixed-latency ACK slave
      for (int v = 0; v < 7; v++) begin
         adr_i = 32'hA000_0000 + 32'(v);
         tgc_i = 8'(v + 8'h30);
         start_msg(vt[v].len, vt[v].we);
         len_eff = (vt[v].len == 7'd0) ? 1 : int'(vt[v].len);
         sent_b = 0; acks_b = 0; nd_cnt = 0; done_cnt = 0; cyc_cnt = 0;
         maxo = 0; ack_sr = '0; k = 0;
         while (done_cnt == 0 && k < 200) begin
            STALL_I = (k < 16) ? vt[v].stall[k] : 1'b0;
            ACK_I   = ack_sr[0];
            #1;
            exp_stb  = (k >= 1) && (sent_b < len_eff) && ((sent_b - acks_b) < 4);
            exp_acc  = exp_stb && !STALL_I;
            exp_done = ACK_I && (acks_b == len_eff - 1) && (acks_b < sent_b);
            if (!exp_stb)               exp_cti = 3'b000;
            else if (len_eff == 1)      exp_cti = 3'b000;
            else if (sent_b == len_eff - 1) exp_cti = 3'b111;
            else                        exp_cti = 3'b010;
            chk($sformatf("v%0d k%0d cyc", v, k), CYC_O, 1);
            chk($sformatf("v%0d k%0d we", v, k), WE_O, vt[v].we);
            chk($sformatf("v%0d k%0d stb", v, k), STB_O, exp_stb);
            chk($sformatf("v%0d k%0d cti", v, k), CTI_O, exp_cti);
            chk($sformatf("v%0d k%0d next_data", v, k), next_data_o,
                exp_acc && (sent_b != len_eff - 1));
            chk($sformatf("v%0d k%0d done", v, k), done_o, exp_done);
            if (k == 0) begin
               chk($sformatf("v%0d adr bypass", v), ADR_O, adr_i);
               chk($sformatf("v%0d tgc bypass", v), TGC_O, tgc_i);
            end
            if (CYC_O) cyc_cnt++;
            if (next_data_o) nd_cnt++;
            if (done_o) done_cnt++;
            if (ACK_I && acks_b < sent_b) acks_b++;
            if (exp_acc) sent_b++;
            if (sent_b - acks_b > maxo) maxo = sent_b - acks_b;
            ack_sr = ack_sr >> 1;
            if (exp_acc) ack_sr[vt[v].lat - 1] = 1'b1;
            @(negedge clk);
            k++;
         end
         STALL_I = 1'b0; ACK_I = 1'b0;
         #1;
         chk($sformatf("v%0d done count", v), done_cnt, 1);
         chk($sformatf("v%0d beats", v), sent_b, vt[v].beats);
         chk($sformatf("v%0d next_data count", v), nd_cnt, vt[v].nd);
         chk($sformatf("v%0d max outstanding", v), maxo, vt[v].maxo);
         chk($sformatf("v%0d cyc cycles", v), cyc_cnt, vt[v].cyc);
         chk($sformatf("v%0d cyc after done", v), CYC_O, 0);
         chk($sformatf("v%0d busy after done", v), busy_o, 0);
      end

      // RTY on the third beat, then three more RTYs: retries 1..3, fourth fails
      start_msg(7'd4, 1'b0);
      #1; chk("rty req stb", STB_O, 0);
      @(negedge clk); #1; chk("rty beat0 stb", STB_O, 1);
      @(negedge clk); #1; chk("rty beat1 cti", CTI_O, 3'b010);
      @(negedge clk);
      RTY_I = 1'b1; #1;
      chk("rty1 retry", retry_o, 1);
      chk("rty1 err", err_o, 0);
      chk("rty1 next_data", next_data_o, 0);
      for (int r = 1; r <= 4; r++) begin
         if (r > 1) begin
            RTY_I = 1'b1; #1;
            chk($sformatf("rty%0d retry", r), retry_o, r <= 3);
            chk($sformatf("rty%0d err", r), err_o, r == 4);
         end
         @(negedge clk);
         RTY_I = 1'b0; #1;
         if (r <= 3) begin
            count_backoff(n);
            chk($sformatf("rty%0d backoff cycles", r), n, 8);
            chk($sformatf("rty%0d req stb", r), STB_O, 0);
            @(negedge clk); #1;
            chk($sformatf("rty%0d restart stb", r), STB_O, 1);
            chk($sformatf("rty%0d restart cti", r), CTI_O, 3'b010);
         end else begin
            chk("rty fail cyc", CYC_O, 0);
            chk("rty fail busy", busy_o, 0);
         end
      end

      // ERR_I and ACK_I together on the only beat: error wins
      start_msg(7'd1, 1'b1);
      @(negedge clk);
      @(negedge clk);
      ERR_I = 1'b1; ACK_I = 1'b1; #1;
      chk("err+ack err", err_o, 1);
      chk("err+ack done", done_o, 0);
      chk("err+ack retry", retry_o, 0);
      @(negedge clk);
      ERR_I = 1'b0; ACK_I = 1'b0; #1;
      chk("err+ack cyc next", CYC_O, 0);
      chk("err+ack busy next", busy_o, 0);

      // Slave never answers a single-beat read
      start_msg(7'd1, 1'b0);
      @(negedge clk);
      @(negedge clk);
`ifdef WB_MST_TIMEOUT_EN
      for (int s = 1; s <= 16; s++) begin
         #1;
         if (s >= 15) chk($sformatf("watchdog err s%0d", s), err_o, s == 16);
         @(negedge clk);
      end
      #1; chk("watchdog idle", busy_o, 0);
      start_msg(7'd1, 1'b0);
      @(negedge clk);
      @(negedge clk);
`else
      n = 0;
      repeat (1000) begin
         #1;
         if (CYC_O && !err_o) n++;
         @(negedge clk);
      end
      chk("no watchdog cyc held", n, 1000);
`endif

      // Reset asserted in the same cycle as the final ACK: no done pulse
      ACK_I = 1'b1; rst = 1'b1; #1;
      chk("rst mid done", done_o, 0);
      @(negedge clk);
      ACK_I = 1'b0; rst = 1'b0; #1;
      chk("rst mid cyc", CYC_O, 0);
      chk("rst mid stb", STB_O, 0);
      chk("rst mid busy", busy_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
